// File: rtl/pc_pkg.sv
// Shared PC-unit definitions: next-PC select encodings, status bit indices
// and small helpers used by pc_unit and its bench.
package pc_pkg;

  typedef enum logic [2:0] {
    PCSRC_SEQ = 3'b000,
    PCSRC_BR  = 3'b001,
    PCSRC_JR  = 3'b010,
    PCSRC_J   = 3'b011,
    PCSRC_EXC = 3'b100
  } pcsrc_e;

  localparam int ST_MISALIGN     = 0;
  localparam int ST_BAD_SEL      = 1;
  localparam int ST_RAS_MISMATCH = 2;
  localparam int ST_W            = 3;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] ptr_inc_s;
  logic [PTR_W-1:0] ptr_dec_s;
  logic [CNT_W-1:0] cnt_r;

  // ptr_r is the next free slot, so the top of stack sits one slot below it
  assign ptr_inc_s = (ptr_r == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : ptr_r + PTR_W'(1);
  assign ptr_dec_s = (ptr_r == PTR_W'(0)) ? PTR_W'(DEPTH - 1) : ptr_r - PTR_W'(1);
  assign top       = mem_r[ptr_dec_s];
  assign empty     = (cnt_r == CNT_W'(0));
  assign full      = (cnt_r == CNT_W'(DEPTH));

  // Stack storage, pointer and saturating occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= PTR_W'(0);
      cnt_r <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= W'(0);
      end
    end else if (push) begin
      mem_r[ptr_r] <= push_data;
      ptr_r        <= ptr_inc_s;
      if (!full) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      ptr_r <= ptr_dec_s;
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC selection and sticky error status.
// Optional return-address-stack checker enabled by defining PC_RAS_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(32'h0000_0000),
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(32'h0000_0080),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            PCWrite,
  input  logic [2:0]      PCSrc,
  input  logic [31:0]     immediate_32,
  input  logic [PC_W-1:0] read_data1,
  input  logic [25:0]     addr26,
  input  logic            is_call,
  input  logic            is_return,
  input  logic            clr_err,
  output logic [PC_W-1:0] PCOut,
  output logic [PC_W-1:0] PCPlus4,
  output logic [2:0]      status
);

  logic [PC_W-1:0] pc_r;
  logic [ST_W-1:0] status_r;
  logic [PC_W-1:0] next_pc_s;
  logic [ST_W-1:0] err_s;
  logic [PC_W-1:0] imm_sext_s;
  logic [PC_W-1:0] branch_off_s;
  logic            ras_mismatch_s;

  assign PCPlus4      = pc_r + PC_W'(4);
  assign imm_sext_s   = PC_W'($signed(immediate_32));
  assign branch_off_s = {imm_sext_s[PC_W-3:0], 2'b00};

`ifdef PC_RAS_EN
  logic            ras_push_s;
  logic            ras_pop_s;
  logic [PC_W-1:0] ras_top_s;
  logic            ras_empty_s;
  logic            ras_unused_full_s;

  assign ras_push_s = PCWrite && (PCSrc == PCSRC_J) && is_call;
  assign ras_pop_s  = PCWrite && (PCSrc == PCSRC_JR) && is_return && !ras_empty_s;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (CLK),
    .rst_n     (Reset),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .push_data (PCPlus4),
    .top       (ras_top_s),
    .empty     (ras_empty_s),
    .full      (ras_unused_full_s)
  );

  // The stack only observes returns; it never steers the PC
  assign ras_mismatch_s = ras_pop_s && (ras_top_s != read_data1);
`else
  logic unused_ras_s;
  assign unused_ras_s   = is_call ^ is_return;
  assign ras_mismatch_s = 1'b0;
`endif

  // Next-PC selection and per-update error detection
  always_comb begin
    next_pc_s = pc_r;
    err_s     = 3'b000;
    case (pcsrc_e'(PCSrc))
      PCSRC_SEQ: next_pc_s = PCPlus4;
      PCSRC_BR:  next_pc_s = PCPlus4 + branch_off_s;
      PCSRC_JR: begin
        if (is_word_aligned(read_data1[1:0])) begin
          next_pc_s = read_data1;
        end else begin
          next_pc_s            = EXC_VEC;
          err_s[ST_MISALIGN]   = 1'b1;
        end
      end
      PCSRC_J:   next_pc_s = {PCPlus4[PC_W-1:28], addr26, 2'b00};
      PCSRC_EXC: next_pc_s = EXC_VEC;
      default: begin
        next_pc_s         = pc_r;
        err_s[ST_BAD_SEL] = 1'b1;
      end
    endcase
    err_s[ST_RAS_MISMATCH] = ras_mismatch_s;
  end

  // PC register; updates only when the control FSM enables it
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pc_r <= RESET_VEC;
    end else if (PCWrite) begin
      pc_r <= next_pc_s;
    end
  end

  // Sticky status: a new error in the same cycle wins over clr_err
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      status_r <= 3'b000;
    end else begin
      status_r <= (clr_err ? 3'b000 : status_r) | (PCWrite ? err_s : 3'b000);
    end
  end

  assign PCOut  = pc_r;
  assign status = status_r;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit; RAS scenarios run only when PC_RAS_EN is defined.
module tb_pc_unit;
  import pc_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        PCWrite;
  logic [2:0]  PCSrc;
  logic [31:0] immediate_32;
  logic [31:0] read_data1;
  logic [25:0] addr26;
  logic        is_call;
  logic        is_return;
  logic        clr_err;
  logic [31:0] PCOut;
  logic [31:0] PCPlus4;
  logic [2:0]  status;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [2:0]  st;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_pc;
  logic [2:0]  m_st;
  logic [31:0] m_ras[$];

  pc_unit dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .PCWrite      (PCWrite),
    .PCSrc        (PCSrc),
    .immediate_32 (immediate_32),
    .read_data1   (read_data1),
    .addr26       (addr26),
    .is_call      (is_call),
    .is_return    (is_return),
    .clr_err      (clr_err),
    .PCOut        (PCOut),
    .PCPlus4      (PCPlus4),
    .status       (status)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Predict the result, queue it, apply one clock, then compare against the queue
  task automatic step(input string tag, input logic wr, input logic [2:0] src,
                      input logic [31:0] imm, input logic [31:0] rd1, input logic [25:0] a26,
                      input logic call, input logic ret, input logic clr);
    logic [31:0] np;
    logic [31:0] p4;
    logic [2:0]  e;
    exp_t        x;
    p4 = m_pc + 32'd4;
    np = m_pc;
    e  = 3'b000;
    case (src)
      3'd0: np = p4;
      3'd1: np = p4 + (imm << 2);
      3'd2: begin
        if (rd1[1:0] == 2'b00) np = rd1;
        else begin
          np   = 32'h0000_0080;
          e[0] = 1'b1;
        end
      end
      3'd3: np = {p4[31:28], a26, 2'b00};
      3'd4: np = 32'h0000_0080;
      default: e[1] = 1'b1;
    endcase
`ifdef PC_RAS_EN
    if (wr && src == 3'd3 && call) begin
      if (m_ras.size() == 4) void'(m_ras.pop_front());
      m_ras.push_back(p4);
    end
    if (wr && src == 3'd2 && ret && m_ras.size() > 0) begin
      if (m_ras.pop_back() != rd1) e[2] = 1'b1;
    end
`endif
    if (wr) m_pc = np;
    m_st = (clr ? 3'b000 : m_st) | (wr ? e : 3'b000);
    x.tag = tag;
    x.pc  = m_pc;
    x.st  = m_st;
    sb_q.push_back(x);

    PCWrite      = wr;
    PCSrc        = src;
    immediate_32 = imm;
    read_data1   = rd1;
    addr26       = a26;
    is_call      = call;
    is_return    = ret;
    clr_err      = clr;
    @(posedge CLK);
    #1;
    x = sb_q.pop_front();
    chk({x.tag, ".pc"}, PCOut, x.pc);
    chk({x.tag, ".st"}, {29'd0, status}, {29'd0, x.st});
    chk({x.tag, ".p4"}, PCPlus4, x.pc + 32'd4);
  endtask

  // Reset pulse placed between clock edges while an update is pending
  task automatic mid_reset(input string tag);
    PCWrite = 1'b1;
    PCSrc   = 3'd0;
    clr_err = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    chk({tag, ".pc"}, PCOut, 32'h0);
    chk({tag, ".st"}, {29'd0, status}, 32'h0);
    m_pc = 32'h0;
    m_st = 3'b000;
    m_ras.delete();
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    Reset        = 1'b0;
    PCWrite      = 1'b0;
    PCSrc        = 3'd0;
    immediate_32 = 32'h0;
    read_data1   = 32'h0;
    addr26       = 26'h0;
    is_call      = 1'b0;
    is_return    = 1'b0;
    clr_err      = 1'b0;
    m_pc         = 32'h0;
    m_st         = 3'b000;
    #12;
    chk("rst.pc", PCOut, 32'h0);
    chk("rst.st", {29'd0, status}, 32'h0);
    @(negedge CLK);
    Reset = 1'b1;

    step("seq1", 1'b1, 3'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0);
    step("seq2", 1'b1, 3'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0);
    step("seq3", 1'b1, 3'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0);
    chk("seq.c", PCOut, 32'h0000_000C);

    step("jr100", 1'b1, 3'd2, 32'h0, 32'h100, 26'h0, 1'b0, 1'b0, 1'b0);
    step("br_neg", 1'b1, 3'd1, 32'hFFFF_FFFE, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0);
    chk("br.fc", PCOut, 32'h0000_00FC);
    step("jr100b", 1'b1, 3'd2, 32'h0, 32'h100, 26'h0, 1'b0, 1'b0, 1'b0);
    step("br_hold", 1'b0, 3'd1, 32'hFFFF_FFFE, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0);
    chk("hold.100", PCOut, 32'h0000_0100);
    step("br_pos", 1'b1, 3'd1, 32'h0000_0010, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0);

    step("jr_hi", 1'b1, 3'd2, 32'h0, 32'h1000_0000, 26'h0, 1'b0, 1'b0, 1'b0);
    step("jmp", 1'b1, 3'd3, 32'h0, 32'h0, 26'h000_0040, 1'b0, 1'b0, 1'b0);
    chk("jmp.tgt", PCOut, 32'h1000_0100);

    step("jr_top", 1'b1, 3'd2, 32'h0, 32'hFFFF_FFFC, 26'h0, 1'b0, 1'b0, 1'b0);
    chk("wrap.p4", PCPlus4, 32'h0);
    step("seq_wrap", 1'b1, 3'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0);

    step("jr_mis", 1'b1, 3'd2, 32'h0, 32'h203, 26'h0, 1'b0, 1'b0, 1'b0);
    chk("mis.pc", PCOut, 32'h0000_0080);
    chk("mis.st", {29'd0, status}, 32'h1);
    step("clr", 1'b0, 3'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0, 1'b1);
    chk("clr.st", {29'd0, status}, 32'h0);
    step("clr_vs_set", 1'b1, 3'd2, 32'h0, 32'h203, 26'h0, 1'b0, 1'b0, 1'b1);
    chk("prio.st", {29'd0, status}, 32'h1);
    step("clr2", 1'b0, 3'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0, 1'b1);
    step("nowr_err", 1'b0, 3'd6, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0);

    step("bad_sel", 1'b1, 3'd6, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0);
    chk("bad.pc", PCOut, 32'h0000_0080);
    chk("bad.st", {29'd0, status}, 32'h2);

    mid_reset("mrst");
    step("post_rst", 1'b1, 3'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0);
    chk("post_rst.4", PCOut, 32'h4);
    step("exc", 1'b1, 3'd4, 32'h0, 32'h0, 26'h0, 1'b1, 1'b1, 1'b0);
    step("call_ign", 1'b1, 3'd3, 32'h0, 32'h0, 26'h000_0001, 1'b1, 1'b0, 1'b0);
    step("ret_ign", 1'b1, 3'd2, 32'h0, 32'h44, 26'h0, 1'b0, 1'b1, 1'b0);

`ifdef PC_RAS_EN
    mid_reset("rrst");
    for (int i = 0; i < 5; i++) begin
      step("jal", 1'b1, 3'd3, 32'h0, 32'h0, 26'((m_pc + 32'd4) >> 2), 1'b1, 1'b0, 1'b0);
    end
    chk("jal.pc", PCOut, 32'h14);
    step("ret14", 1'b1, 3'd2, 32'h0, 32'h14, 26'h0, 1'b0, 1'b1, 1'b0);
    step("ret10", 1'b1, 3'd2, 32'h0, 32'h10, 26'h0, 1'b0, 1'b1, 1'b0);
    step("ret0c", 1'b1, 3'd2, 32'h0, 32'h0C, 26'h0, 1'b0, 1'b1, 1'b0);
    step("ret08", 1'b1, 3'd2, 32'h0, 32'h08, 26'h0, 1'b0, 1'b1, 1'b0);
    chk("ras_ok.st", {29'd0, status}, 32'h0);
    step("ret_empty", 1'b1, 3'd2, 32'h0, 32'h40, 26'h0, 1'b0, 1'b1, 1'b0);
    chk("ras_empty.st", {29'd0, status}, 32'h0);
    step("jal_x", 1'b1, 3'd3, 32'h0, 32'h0, 26'h000_0100, 1'b1, 1'b0, 1'b0);
    step("ret_bad", 1'b1, 3'd2, 32'h0, 32'h200, 26'h0, 1'b0, 1'b1, 1'b0);
    chk("ras_bad.st", {29'd0, status}, 32'h4);
    chk("ras_bad.pc", PCOut, 32'h200);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning PC width in bits; legal range 32..64.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-003 SHALL have parameter EXC_VEC, default 32'h0000_0080, meaning exception/trap target.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries; legal range 2..16.
REQ-005 SHALL have port CLK  in  1  clock; state changes on the rising edge only.
REQ-006 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port PCWrite  in  1  PC update enable from the control FSM.
REQ-008 SHALL have port PCSrc  in  3  next-PC select.
REQ-009 SHALL have port immediate_32  in  32  sign-extended branch offset, in words.
REQ-010 SHALL have port read_data1  in  PC_W  register jump target.
REQ-011 SHALL have port addr26  in  26  jump field.
REQ-012 SHALL have port is_call  in  1  current jump is a link (jal) jump.
REQ-013 SHALL have port is_return  in  1  current jr is a return ($ra).
REQ-014 SHALL have port clr_err  in  1  clears the sticky status bits.
REQ-015 SHALL have port PCOut  out  PC_W  registered PC.
REQ-016 SHALL have port PCPlus4  out  PC_W  combinational PCOut+4.
REQ-017 SHALL have port status  out  3  sticky flags {ras_mismatch, bad_sel, misalign}.

Function
REQ-018 SHALL define PCPlus4 as PCOut+4 modulo 2^PC_W.
REQ-019 SHALL update PCOut only on a rising CLK with PCWrite=1, and SHALL hold PCOut otherwise.
REQ-020 SHALL, for PCSrc=000, load PCPlus4.
REQ-021 SHALL, for PCSrc=001, load PCPlus4 + (sign-extended immediate_32 << 2), wrapping modulo 2^PC_W.
REQ-022 SHALL, for PCSrc=010, load read_data1 when read_data1[1:0]=00; otherwise load EXC_VEC and set status[0].
REQ-023 SHALL, for PCSrc=011, load {PCPlus4[PC_W-1:28], addr26, 2'b00}.
REQ-024 SHALL, for PCSrc=100, load EXC_VEC.
REQ-025 SHALL, for PCSrc=101..111, hold PCOut and set status[1].
REQ-026 SHALL evaluate status flag setting only when PCWrite=1; flags stay set until clr_err=1 or reset.
REQ-027 SHALL give set priority over clear when clr_err=1 and a new error occur in the same cycle.
REQ-028 SHALL ignore is_call unless PCSrc=011, and is_return unless PCSrc=010; both can never act in the same cycle.

Reset
REQ-029 SHALL, while Reset=0, asynchronously force PCOut=RESET_VEC, status=000, RAS count=0 and RAS pointer=0.
REQ-030 SHALL abandon any in-progress update when reset asserts mid-cycle; the first update after release uses the RESET_VEC base.

Configuration
REQ-031 SHALL, with PC_RAS_EN defined, push PCPlus4 onto the RAS on a qualified call update.
REQ-032 SHALL, with PC_RAS_EN defined, pop the RAS on a qualified return update and set status[2] if the popped value differs from read_data1.
REQ-033 SHALL, when the RAS is full, overwrite the oldest entry on push (circular) with count saturating at RAS_DEPTH.
REQ-034 SHALL, when the RAS is empty, leave pointer and status unchanged on a return.
REQ-035 SHALL, without PC_RAS_EN, ignore is_call and is_return, hold status[2]=0 and instantiate no RAS storage.
REQ-036 SHALL never let the RAS alter the PC value loaded; the RAS is a checker only.

Structure
REQ-037 SHALL place the PCSrc encodings (PCSRC_SEQ, PCSRC_BR, PCSRC_JR, PCSRC_J, PCSRC_EXC) and status bit indices in shared package pc_pkg.
REQ-038 SHALL implement the RAS as sub-module pc_ras (push, pop, top, empty, full), instantiated only under PC_RAS_EN.

Verification
REQ-039 SHALL cover: Reset=0 then 1, PCWrite=1, PCSrc=000 x3 -> PCOut 0, 4, 8, C.
REQ-040 SHALL cover: PCOut=0x100, PCSrc=001, imm=0xFFFFFFFE -> PCOut=0xFC; with PCWrite=0 -> PCOut stays 0x100.
REQ-041 SHALL cover: PCOut=0x10000000, PCSrc=011, addr26=0x0000040 -> PCOut=0x10000100.
REQ-042 SHALL cover: PCSrc=010, read_data1=0x203 -> PCOut=0x80 and status=001; clr_err -> status=000.
REQ-043 SHALL cover: PCSrc=110 -> PCOut held and status[1]=1; Reset pulse mid-run -> PCOut=0 and status=000 immediately.
REQ-044 SHALL cover, with PC_RAS_EN: 5 jal pushes at PCPlus4 0x4..0x14 with depth 4, then 4 returns at matching targets -> status[2]=0; a 5th return on the empty RAS -> no change; a return with a wrong target -> status[2]=1.
